// File: rtl/ca_conv_pkg.sv
// Shared conv read-path types: read-generator FSM encoding and default address widths.
// Pure declarations, used by conv_read_gen and the design controller.
package ca_conv_pkg;

    localparam int DEF_FILT_ADDR_LEN = 4;
    localparam int DEF_IF_ADDR_LEN   = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_ADVANCE = 2'd2,
        ST_DONE    = 2'd3
    } rd_state_t;

endpackage

// File: rtl/conv_read_gen_if.sv
// IF/filter read-address stream from the read generator to the MAC.
// Valid/ready: a pair is taken on any cycle where rd_valid and rd_ready are both high.
interface conv_read_gen_if import ca_conv_pkg::*; #(
    parameter int IF_ADDR_LEN   = DEF_IF_ADDR_LEN,
    parameter int FILT_ADDR_LEN = DEF_FILT_ADDR_LEN
);
    logic                     rd_valid;
    logic                     rd_ready;
    logic [IF_ADDR_LEN-1:0]   if_raddr;
    logic [FILT_ADDR_LEN-1:0] filt_raddr;
    logic                     rd_last;

    modport master (
        output rd_valid, if_raddr, filt_raddr, rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_valid, if_raddr, filt_raddr, rd_last,
        output rd_ready
    );
endinterface

// File: rtl/rd_gen_tap_counter.sv
// Tap index counter: load/clear to a start value, count on enable, flag the terminal tap.
// Count updates the cycle after en; the flag is combinational on the current count.
module rd_gen_tap_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] last_val,
    output logic [W-1:0] count,
    output logic         term
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign term = (count == last_val);

endmodule

// File: rtl/conv_read_gen.sv
// Walks one filter window per request, streaming IF/filter address pairs; first pair 1 cycle after start,
// rd_ready low stalls the pair in place. Optional perf counters under RDGEN_PERF_CNT_EN.
module conv_read_gen import ca_conv_pkg::*; #(
    parameter int FILT_ADDR_LEN = DEF_FILT_ADDR_LEN,
    parameter int IF_ADDR_LEN   = DEF_IF_ADDR_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reset_all,
    input  logic                     start_rd_gen,
    input  logic [FILT_ADDR_LEN-1:0] filt_len,
    input  logic [IF_ADDR_LEN-1:0]   stride,
    input  logic [IF_ADDR_LEN:0]     if_count,
    conv_read_gen_if.master          rd,
    output logic                     psum_done,
    output logic                     stride_count_flag,
    output logic                     full_done,
    output logic                     ready_to_get
`ifdef RDGEN_PERF_CNT_EN
    ,
    output logic [IF_ADDR_LEN:0]     win_count,
    output logic [15:0]              stall_count
`endif
);

    localparam int BW = IF_ADDR_LEN + 1;
    localparam int CW = IF_ADDR_LEN + 2;

    rd_state_t                state;
    rd_state_t                state_nxt;
    logic [BW-1:0]            base;
    logic [FILT_ADDR_LEN-1:0] flen_q;
    logic [FILT_ADDR_LEN-1:0] tap;
    logic                     tap_term;
    logic [CW-1:0]            win_end;
    logic [CW-1:0]            base_sum;
    logic [BW-1:0]            addr_sum;
    logic                     win_start;
    logic                     beat;

    // One extra bit on the compares so base+len / base+stride never wrap.
    assign win_end      = CW'(base) + CW'(filt_len);
    assign base_sum     = CW'(base) + CW'(stride);
    assign addr_sum     = base + BW'(tap);
    assign ready_to_get = (filt_len == '0)
                       || ((stride == '0) && (base != '0))
                       || (win_end > CW'(if_count));
    assign win_start    = ((state == ST_IDLE) || (state == ST_DONE)) && start_rd_gen && !ready_to_get;
    assign beat         = (state == ST_RUN) && rd.rd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (reset_all) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (win_start) state_nxt = ST_RUN;
            ST_RUN:     if (beat && tap_term) state_nxt = ST_ADVANCE;
            ST_ADVANCE: state_nxt = ST_DONE;
            ST_DONE:    state_nxt = win_start ? ST_RUN : ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd.rd_valid       = (state == ST_RUN);
        rd.rd_last        = (state == ST_RUN) && tap_term;
        rd.if_raddr       = (state == ST_RUN) ? addr_sum[IF_ADDR_LEN-1:0] : '0;
        rd.filt_raddr     = (state == ST_RUN) ? tap : '0;
        psum_done         = (state == ST_ADVANCE);
        full_done         = (state == ST_DONE);
        stride_count_flag = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base   <= '0;
            flen_q <= '0;
        end else if (reset_all) begin
            base   <= '0;
            flen_q <= '0;
        end else begin
            if (win_start) begin
                flen_q <= filt_len;
            end
            if (state == ST_ADVANCE) begin
                base <= (base_sum > CW'(if_count)) ? if_count : base_sum[BW-1:0];
            end
        end
    end

    rd_gen_tap_counter #(
        .W (FILT_ADDR_LEN)
    ) u_tap_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (reset_all),
        .load     (win_start),
        .load_val ('0),
        .en       (beat),
        .last_val (flen_q - 1'b1),
        .count    (tap),
        .term     (tap_term)
    );

`ifdef RDGEN_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_count   <= '0;
            stall_count <= '0;
        end else if (reset_all) begin
            win_count   <= '0;
            stall_count <= '0;
        end else begin
            if (state == ST_ADVANCE) begin
                win_count <= win_count + 1'b1;
            end
            if ((state == ST_RUN) && !rd.rd_ready && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end
`endif

endmodule
